// File: rtl/key_press_ctrl_pkg.sv
// Shared types and default 50 MHz timing constants for the front-panel key path.
package key_ctrl_pkg;

  // Press-classification states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    LONG    = 2'd2,
    LOCKOUT = 2'd3
  } key_state_e;

  // Default timing at a 50 MHz FPGA_CLK.
  localparam int unsigned DEBOUNCE_20MS = 1_000_000;
  localparam int unsigned HOLD_3S       = 150_000_000;
  localparam int unsigned REPEAT_500MS  = 25_000_000;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_press_ctrl_if.sv
// Key input / event output bundle between the key controller and its consumers.
interface key_press_ctrl_if;
  logic key_raw;
  logic en;
  logic key_level;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic hold_active;

  // Consumer side: drives the pin and enable, receives events.
  modport master (
    output key_raw, en,
    input  key_level, short_pulse, long_pulse, repeat_pulse, hold_active
  );

  // Controller side.
  modport slave (
    input  key_raw, en,
    output key_level, short_pulse, long_pulse, repeat_pulse, hold_active
  );
endinterface

// File: rtl/key_press_ctrl_debounce.sv
// Two-flop synchroniser plus debounce counter; key_level = 1 means pressed.
module key_debounce
  import key_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC   = DEBOUNCE_20MS,
  parameter int unsigned KEY_ACTIVE_LOW = 1
) (
  input  logic FPGA_CLK,
  input  logic FPGA_RST_N,
  input  logic key_raw,
  output logic key_level
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          key_norm;
  logic [1:0]    sync_q;
  logic          key_sync;
  logic [CW-1:0] cnt_q;

  assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;
  assign key_sync = sync_q[1];

  // Bring the asynchronous pin into the FPGA_CLK domain.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // with = the second stage would copy the first in the same edge.
    if (!FPGA_RST_N) sync_q <= 2'b00;
    else             sync_q <= {sync_q[0], key_norm};
  end

  // Accept a level change only after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      cnt_q     <= '0;
      key_level <= 1'b0;
    end else if (key_sync == key_level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q     <= '0;
      key_level <= ~key_level;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/key_press_ctrl.sv
// Classifies debounced key presses into short / long / auto-repeat event pulses.
module key_press_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC   = DEBOUNCE_20MS,
  parameter int unsigned LONG_CYC       = HOLD_3S,
  parameter int unsigned REPEAT_CYC     = REPEAT_500MS,
  parameter int unsigned KEY_ACTIVE_LOW = 1
) (
  input logic             FPGA_CLK,
  input logic             FPGA_RST_N,
  key_press_ctrl_if.slave bus
);

  localparam int unsigned   HW        = cnt_width(LONG_CYC);
  localparam int unsigned   RW        = cnt_width(REPEAT_CYC);
  // "Reaches" comparisons use the value one below the limit so the event pulse
  // lands exactly LONG_CYC / REPEAT_CYC cycles after its reference cycle.
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);

  logic          key_level;
  key_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          en_q;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          hold_active_q, hold_active_d;

  key_debounce #(
    .DEBOUNCE_CYC   (DEBOUNCE_CYC),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_debounce (
    .FPGA_CLK   (FPGA_CLK),
    .FPGA_RST_N (FPGA_RST_N),
    .key_raw    (bus.key_raw),
    .key_level  (key_level)
  );

  // Next state, counters and registered event pulses.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      hold_d  = '0;
      rep_d   = '0;
    end else if (!en_q && key_level) begin
      // Enabled while the key is already down: ignore this press entirely.
      state_d = LOCKOUT;
      hold_d  = '0;
      rep_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (key_level) begin
            state_d = HELD;
            hold_d  = HW'(1);
          end
        end
        HELD: begin
          // Release takes priority over reaching the long-press threshold.
          if (!key_level) begin
            state_d = IDLE;
            hold_d  = '0;
            short_d = 1'b1;
          end else if (hold_q == HOLD_LAST) begin
            state_d = LONG;
            hold_d  = HOLD_MAX;
            rep_d   = '0;
            long_d  = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        LONG: begin
          // Release takes priority over a repeat boundary.
          if (!key_level) begin
            state_d = IDLE;
            hold_d  = '0;
            rep_d   = '0;
          end else if (rep_q == REP_LAST) begin
            rep_d    = '0;
            repeat_d = 1'b1;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
        LOCKOUT: begin
          if (!key_level) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end
      endcase
    end

    hold_active_d = (state_d == HELD) || (state_d == LONG);
  end

  // State, counters and output registers.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      rep_q         <= '0;
      en_q          <= 1'b0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
      repeat_q      <= 1'b0;
      hold_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      rep_q         <= rep_d;
      en_q          <= bus.en;
      short_q       <= short_d;
      long_q        <= long_d;
      repeat_q      <= repeat_d;
      hold_active_q <= hold_active_d;
    end
  end

  assign bus.key_level    = key_level;
  assign bus.short_pulse  = short_q;
  assign bus.long_pulse   = long_q;
  assign bus.repeat_pulse = repeat_q;
  assign bus.hold_active  = hold_active_q;

endmodule

// File: tb/tb_key_press_ctrl.sv
// Self-checking bench for key_press_ctrl: directed scenarios plus random key
// activity, compared every cycle against a timestamp-based reference model.
module tb_key_press_ctrl;

  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;

  logic FPGA_CLK   = 1'b0;
  logic FPGA_RST_N = 1'b0;

  key_press_ctrl_if bus ();

  key_press_ctrl #(
    .DEBOUNCE_CYC   (DEB),
    .LONG_CYC       (LNG),
    .REPEAT_CYC     (REP),
    .KEY_ACTIVE_LOW (1)
  ) dut (
    .FPGA_CLK   (FPGA_CLK),
    .FPGA_RST_N (FPGA_RST_N),
    .bus        (bus)
  );

  always #5 FPGA_CLK = ~FPGA_CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: press history since reset, plus press bookkeeping.
  bit hist[$];
  int t;
  bit m_lvl, m_press, m_lock, m_en_prev;
  int rise_t;
  bit exp_short, exp_long, exp_rep;

  // Observed event counts per scenario.
  int n_short, n_long, n_rep, n_level_hi;

  // Pressed value driven before edge idx (1-based); zero before reset release.
  function automatic bit h_at(input int idx);
    if (idx < 1 || idx > hist.size()) return 1'b0;
    return hist[idx-1];
  endfunction

  task automatic model_reset();
    hist.delete();
    t = 0;
    m_lvl = 0; m_press = 0; m_lock = 0; m_en_prev = 0;
    rise_t = 0;
  endtask

  // Advance the model over edge t given the enable applied before it.
  task automatic model_edge(input bit en_in);
    bit lvl_prev;
    bit all_diff;
    int e;
    lvl_prev = m_lvl;
    // Level flips once the last DEB synchronised samples all disagree with it.
    all_diff = 1;
    for (int i = 1; i <= DEB; i++)
      if (h_at(t - i - 1) == lvl_prev) all_diff = 0;
    if (all_diff) m_lvl = ~lvl_prev;

    exp_short = 0; exp_long = 0; exp_rep = 0;
    if (!en_in) begin
      m_press = 0; m_lock = 0;
    end else if (!m_en_prev && lvl_prev) begin
      m_lock = 1; m_press = 0;
    end else if (m_lock) begin
      if (!lvl_prev) m_lock = 0;
    end else if (!m_press) begin
      if (lvl_prev) begin
        m_press = 1;
        rise_t  = t - 1;
      end
    end else if (!lvl_prev) begin
      m_press   = 0;
      exp_short = ((t - rise_t) <= LNG);
    end else begin
      e        = t - rise_t;
      exp_long = (e == LNG);
      exp_rep  = (e > LNG) && (((e - LNG) % REP) == 0);
    end
    m_en_prev = en_in;
  endtask

  task automatic clr();
    n_short = 0; n_long = 0; n_rep = 0; n_level_hi = 0;
  endtask

  // One clock: apply inputs, let the edge pass, compare away from the edge.
  task automatic step(input bit press, input bit en_v);
    bus.key_raw = ~press;
    bus.en      = en_v;
    @(posedge FPGA_CLK);
    #1;
    hist.push_back(press);
    t++;
    model_edge(en_v);
    check("key_level",    bus.key_level,    m_lvl);
    check("short_pulse",  bus.short_pulse,  exp_short);
    check("long_pulse",   bus.long_pulse,   exp_long);
    check("repeat_pulse", bus.repeat_pulse, exp_rep);
    check("hold_active",  bus.hold_active,  m_press);
    check("pulse_excl",   32'($countones({bus.short_pulse, bus.long_pulse, bus.repeat_pulse}) <= 1), 1);
    n_short    += int'(bus.short_pulse);
    n_long     += int'(bus.long_pulse);
    n_rep      += int'(bus.repeat_pulse);
    n_level_hi += int'(bus.key_level);
  endtask

  task automatic run(input bit press, input bit en_v, input int n);
    for (int i = 0; i < n; i++) step(press, en_v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},  bus.key_level,    0);
    check({tag, "_short"},  bus.short_pulse,  0);
    check({tag, "_long"},   bus.long_pulse,   0);
    check({tag, "_repeat"}, bus.repeat_pulse, 0);
    check({tag, "_hold"},   bus.hold_active,  0);
  endtask

  initial begin
    bus.key_raw = 1'b1;
    bus.en      = 1'b1;
    model_reset();
    clr();
    repeat (3) @(posedge FPGA_CLK);
    #1;
    check_all_zero("rst");
    FPGA_RST_N = 1'b1;

    // 1: short press of 10 cycles.
    run(0, 1, 5);
    clr();
    run(1, 1, 10);
    run(0, 1, 15);
    check("t1_short_cnt", n_short, 1);
    check("t1_long_cnt",  n_long,  0);

    // 2: long hold of 60 cycles, repeats every REP after the long pulse.
    clr();
    run(1, 1, 60);
    run(0, 1, 15);
    check("t2_long_cnt",   n_long,  1);
    check("t2_repeat_cnt", n_rep,   5);
    check("t2_short_cnt",  n_short, 0);

    // 3: bouncing contact shorter than the debounce window.
    clr();
    for (int i = 0; i < 40; i++) step(((i / 3) % 2) == 0, 1);
    run(0, 1, 8);
    check("t3_level_hi_cycles", n_level_hi, 0);
    check("t3_pulse_cnt", n_short + n_long + n_rep, 0);

    // 4: enable rises while the key is held -> lockout, then a normal press.
    clr();
    run(0, 0, 5);
    run(1, 0, 12);
    run(1, 1, 15);
    check("t4_lock_hold", bus.hold_active, 0);
    check("t4_lock_pulses", n_short + n_long + n_rep, 0);
    run(0, 1, 10);
    run(1, 1, 5);
    run(0, 1, 12);
    check("t4_short_cnt", n_short, 1);
    check("t4_long_cnt",  n_long,  0);

    // 5: release lands on the threshold cycle -> short only; one more -> long.
    clr();
    run(1, 1, LNG - 1);
    run(0, 1, 12);
    check("t5_edge_short", n_short, 1);
    check("t5_edge_long",  n_long,  0);
    clr();
    run(1, 1, LNG);
    run(0, 1, 12);
    check("t5_over_long",  n_long,  1);
    check("t5_over_short", n_short, 0);
    check("t5_over_rep",   n_rep,   0);

    // 6: asynchronous reset in LONG, key still held afterwards.
    clr();
    run(1, 1, 30);
    check("t6_long_cnt", n_long, 1);
    check("t6_in_long",  bus.hold_active, 1);
    FPGA_RST_N = 1'b0;
    #2;
    check_all_zero("t6_rst");
    @(posedge FPGA_CLK);
    #1;
    FPGA_RST_N = 1'b1;
    model_reset();
    clr();
    run(1, 1, 40);
    check("t6_relong_cnt",  n_long, 1);
    check("t6_rerepeat_cnt", n_rep, 1);
    run(0, 1, 12);
    check("t6_short_cnt", n_short, 0);

    // Random key activity with occasional enable drops.
    for (int seg = 0; seg < 60; seg++) begin
      bit p, e;
      int len;
      p   = 1'($urandom_range(0, 1));
      e   = ($urandom_range(0, 9) != 0);
      len = int'($urandom_range(1, 45));
      run(p, e, len);
    end
    run(0, 1, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
